// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a FILL clear sweep after reset, a word-wide loader write port
// and a single-cycle-latency fetch port that faults misaligned or out-of-range addresses.
module instr_mem_ctrl #(
  parameter int          DEPTH = 64,
  parameter logic [31:0] FILL  = 32'h0000_0013,
  parameter int          AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic        instr_fault,
  output logic        busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  state_e      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic        instr_fault_q, instr_fault_d;

  logic [31:0] mem [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic [AW-1:0] ld_idx, fetch_idx;
  logic          ld_ok, fetch_ok;

  // An address is usable only if word-aligned and every bit above the index field is zero.
  assign ld_idx    = ld_addr[AW+1:2];
  assign fetch_idx = fetch_addr[AW+1:2];
  assign ld_ok     = (ld_addr[1:0] == 2'b00)    && (ld_addr[31:AW+2] == '0);
  assign fetch_ok  = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:AW+2] == '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    instr_valid_d = 1'b0;
    instr_out_d   = instr_out_q;
    instr_fault_d = instr_fault_q;
    mem_we        = 1'b0;
    mem_waddr     = ld_idx;
    mem_wdata     = ld_data;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[AW-1:0];
        mem_wdata = FILL;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_READY;
      end
      ST_READY: begin
        mem_we = ld_valid && ld_ok;
        // The read sees the array before this edge's write, giving read-before-write.
        if (fetch_req) begin
          instr_valid_d = 1'b1;
          if (fetch_ok) begin
            instr_out_d   = mem[fetch_idx];
            instr_fault_d = 1'b0;
          end else begin
            instr_out_d   = FILL;
            instr_fault_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      cnt_q         <= '0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= 32'h0;
      instr_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_fault_q <= instr_fault_d;
    end
  end

  // NOTE: the array has no reset; the clear sweep that follows every reset initialises it,
  // and leaving reset off lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy        = (state_q == ST_CLEAR);
  assign ld_ready    = (state_q == ST_READY);
  assign fetch_ready = (state_q == ST_READY);
  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_out_q;
  assign instr_fault = instr_fault_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: stimulus pushes expected fetch results from an
// array model; a negedge monitor pops and compares whenever instr_valid is seen.
module tb_instr_mem_ctrl;
  localparam int          DEPTH = 64;
  localparam logic [31:0] FILL  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0, fetch_req = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0, fetch_addr = '0;
  logic        ld_ready, fetch_ready, instr_valid, instr_fault, busy;
  logic [31:0] instr_out;

  instr_mem_ctrl #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_fault(instr_fault),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        head;
  logic [31:0] ref_mem [DEPTH];
  bit          model_ready = 1'b0;
  logic [31:0] last_out = '0;
  logic        last_fault = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < DEPTH * 4);
  endfunction

  // Monitor: compares every presented result, checks latency, and checks hold when idle.
  always @(negedge clk) begin
    if (!reset) begin
      if (instr_valid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL stray_valid: got instr_out %h with no fetch outstanding", instr_out);
          last_out   = instr_out;
          last_fault = instr_fault;
        end else begin
          head = sb.pop_front();
          check("fetch_cycle", cyc, head.cyc);
          check("fetch_data", instr_out, head.data);
          check("fetch_fault", {31'b0, instr_fault}, {31'b0, head.fault});
          last_out   = head.data;
          last_fault = head.fault;
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          head = sb.pop_front();
          tests++; fails++;
          $display("FAIL missing_valid: got no result at cycle %0d, expected %h", cyc, head.data);
        end
        check("hold_out", instr_out, last_out);
        check("hold_fault", {31'b0, instr_fault}, {31'b0, last_fault});
      end
    end
  end

  // Called at posedge+1; applies one cycle of stimulus and updates the model.
  task automatic drive(input bit ldv, input logic [31:0] lda, input logic [31:0] ldd,
                       input bit fr, input logic [31:0] fa);
    exp_t e;
    ld_valid = ldv; ld_addr = lda; ld_data = ldd;
    fetch_req = fr; fetch_addr = fa;
    if (fr) check("fetch_ready", {31'b0, fetch_ready}, {31'b0, model_ready});
    if (model_ready) begin
      if (fr) begin
        e.data  = addr_ok(fa) ? ref_mem[fa / 4] : FILL;
        e.fault = !addr_ok(fa);
        e.cyc   = cyc + 1;
        sb.push_back(e);
      end
      if (ldv && addr_ok(lda)) ref_mem[lda / 4] = ldd;
    end
    @(posedge clk); #1;
    ld_valid = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    sb.delete();
    model_ready = 1'b0;
    last_out = '0;
    last_fault = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    check("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_instr_fault", {31'b0, instr_fault}, 32'd0);
  endtask

  // Releases reset away from the edge and measures the sweep length.
  task automatic release_and_sweep();
    int n = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) check("sweep_fetch_ready", {31'b0, fetch_ready}, 32'd0);
      if (!busy) break;
    end
    check("sweep_len", n, DEPTH);
    check("ready_ld", {31'b0, ld_ready}, 32'd1);
    check("ready_fetch", {31'b0, fetch_ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
    model_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] a, d;
    #12;
    do_reset();
    release_and_sweep();

    // Full sweep readback, back to back
    for (int i = 0; i < DEPTH; i++) drive(0, '0, '0, 1, 32'(i * 4));
    idle(2);

    // Load then fetch next cycle
    drive(1, 32'h8, 32'h0050_0093, 0, '0);
    drive(0, '0, '0, 1, 32'h8);
    idle(1);

    // Same-cycle load and fetch: old data first, then new
    drive(1, 32'h10, 32'hDEAD_BEEF, 1, 32'h10);
    drive(0, '0, '0, 1, 32'h10);
    idle(1);

    // Faults and dropped loads
    drive(0, '0, '0, 1, 32'h6);
    drive(0, '0, '0, 1, 32'h100);
    drive(1, 32'h102, 32'h1234_5678, 0, '0);
    drive(1, 32'h4000_0000, 32'h8765_4321, 0, '0);
    drive(1, 32'h3, 32'hAAAA_5555, 0, '0);
    drive(0, '0, '0, 1, 32'h0);
    drive(0, '0, '0, 1, 32'hFC);
    idle(2);

    // Randomised mix of loads and fetches
    for (int i = 0; i < 400; i++) begin
      logic ldv, fr;
      logic [31:0] la, fa;
      ldv = ($urandom_range(0, 99) < 50);
      fr  = ($urandom_range(0, 99) < 70);
      la  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, DEPTH - 1) * 4) : $urandom;
      case ($urandom_range(0, 9))
        0:       fa = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        1:       fa = $urandom | 32'h0000_0100;
        default: fa = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      d = $urandom;
      drive(ldv, la, d, fr, fa);
    end
    idle(3);

    // Reset with a fetch in flight: its result must never appear
    drive(1, 32'h20, 32'hCAFE_F00D, 1, 32'h20);
    do_reset();
    release_and_sweep();
    drive(0, '0, '0, 1, 32'h20);
    idle(2);

    // Reset 20 cycles into the sweep: a full sweep restarts
    do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    do_reset();
    release_and_sweep();
    a = 32'h8;
    drive(0, '0, '0, 1, a);
    idle(4);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
